// File: rtl/demux1to2_32_if.sv
// demux1to2_32_if: handshake bundle between one producer, the 1-to-2 demux
// and its two consumers.
//   in_valid/in_sel/in_data/in_ready : producer side, in_sel=1 -> a, 0 -> b
//   a_valid/a_data/a_ready           : consumer a
//   b_valid/b_data/b_ready           : consumer b
//   a_count/b_count                  : FIFO occupancy 0..2
//   a_total/b_total                  : words delivered per output, wrapping
// Modport slave is the demux; master is the producer/consumer environment.
interface demux1to2_32_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;

    logic [1:0]       a_count;
    logic [1:0]       b_count;
    logic [31:0]      a_total;
    logic [31:0]      b_total;

    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data,
               a_count, b_count, a_total, b_total
    );

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data,
               a_count, b_count, a_total, b_total
    );
endinterface

// File: rtl/demux1to2_32.sv
// demux1to2_32: registered 1-to-2 demultiplexer. Each accepted word is steered
// by in_sel into a private 2-entry FIFO (1 -> a, 0 -> b); each FIFO drains to
// its own consumer with valid/ready. Pop counts per output wrap modulo 2^32.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : demux1to2_32_if.slave (producer, consumer a, consumer b,
//              occupancy and delivered-word totals)
module demux1to2_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    demux1to2_32_if.slave        bus
);
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned TOT_W = 32;

    // FIFO a state
    logic [WIDTH-1:0] a_mem [DEPTH];
    logic             a_wptr;
    logic             a_rptr;
    logic [CNT_W-1:0] a_cnt;
    logic [TOT_W-1:0] a_tot;

    // FIFO b state
    logic [WIDTH-1:0] b_mem [DEPTH];
    logic             b_wptr;
    logic             b_rptr;
    logic [CNT_W-1:0] b_cnt;
    logic [TOT_W-1:0] b_tot;

    logic a_full_c, b_full_c;
    logic in_ready_c, accept_c;
    logic a_push_c, a_pop_c, b_push_c, b_pop_c;

    // Handshake decode; in_ready sees only in_sel and registered occupancy,
    // so a full FIFO refuses a push even when it pops in the same cycle.
    always_comb begin
        a_full_c   = (a_cnt == CNT_W'(DEPTH));
        b_full_c   = (b_cnt == CNT_W'(DEPTH));
        in_ready_c = bus.in_sel ? !a_full_c : !b_full_c;
        accept_c   = bus.in_valid && in_ready_c;
        a_push_c   = accept_c && bus.in_sel;
        b_push_c   = accept_c && !bus.in_sel;
        a_pop_c    = (a_cnt != CNT_W'(0)) && bus.a_ready;
        b_pop_c    = (b_cnt != CNT_W'(0)) && bus.b_ready;
    end

    // FIFO a storage, pointers, occupancy and delivered total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) a_mem[i] <= '0;
            a_wptr <= 1'b0;
            a_rptr <= 1'b0;
            a_cnt  <= '0;
            a_tot  <= '0;
        end else begin
            if (a_push_c) begin
                a_mem[a_wptr] <= bus.in_data;
                a_wptr        <= ~a_wptr;
            end
            if (a_pop_c) begin
                a_rptr <= ~a_rptr;
                a_tot  <= a_tot + TOT_W'(1);
            end
            case ({a_push_c, a_pop_c})
                2'b10:   a_cnt <= a_cnt + CNT_W'(1);
                2'b01:   a_cnt <= a_cnt - CNT_W'(1);
                default: a_cnt <= a_cnt;
            endcase
        end
    end

    // FIFO b storage, pointers, occupancy and delivered total
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) b_mem[i] <= '0;
            b_wptr <= 1'b0;
            b_rptr <= 1'b0;
            b_cnt  <= '0;
            b_tot  <= '0;
        end else begin
            if (b_push_c) begin
                b_mem[b_wptr] <= bus.in_data;
                b_wptr        <= ~b_wptr;
            end
            if (b_pop_c) begin
                b_rptr <= ~b_rptr;
                b_tot  <= b_tot + TOT_W'(1);
            end
            case ({b_push_c, b_pop_c})
                2'b10:   b_cnt <= b_cnt + CNT_W'(1);
                2'b01:   b_cnt <= b_cnt - CNT_W'(1);
                default: b_cnt <= b_cnt;
            endcase
        end
    end

    // Outputs come straight from registered state; data is the head slot.
    assign bus.in_ready = in_ready_c;
    assign bus.a_valid  = (a_cnt != CNT_W'(0));
    assign bus.a_data   = a_mem[a_rptr];
    assign bus.b_valid  = (b_cnt != CNT_W'(0));
    assign bus.b_data   = b_mem[b_rptr];
    assign bus.a_count  = a_cnt;
    assign bus.b_count  = b_cnt;
    assign bus.a_total  = a_tot;
    assign bus.b_total  = b_tot;
endmodule

// File: doc/demux1to2_32.md
# demux1to2_32

Registered 1-to-2 demultiplexer with valid/ready handshaking. It steers a 32-bit word from one producer to one of two consumers and is the routing counterpart of the 2-to-1 selector used in the datapath. The datapath uses it to split CPU write traffic between data memory and the memory-mapped I/O path. Each output has its own 2-entry FIFO, so a stalled consumer never blocks the other output's drained traffic beyond its own buffer.

## Interface
- WIDTH, 32, data width of input and both outputs
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers a word
- in_sel  input  1  destination: 1 routes to output a, 0 routes to output b (same polarity as the 2-to-1 selector)
- in_data  input  WIDTH  word to route
- in_ready  output  1  word accepted this cycle when in_valid && in_ready
- a_valid  output  1  output a FIFO non-empty
- a_data  output  WIDTH  output a FIFO head
- a_ready  input  1  consumer a takes the head when a_valid && a_ready
- b_valid, b_data, b_ready  same as the a_* ports, for output b
- a_count, b_count  output  2  FIFO occupancy, 0..2
- a_total, b_total  output  32  words delivered (popped) per output, wrap modulo 2^32

## Operation
- Per output: 2-entry circular FIFO with 1-bit read and write pointers and a 2-bit occupancy counter.
- Push condition for a: in_valid && in_ready && in_sel. Push condition for b: in_valid && in_ready && !in_sel.
- Pop condition: x_valid && x_ready.
- in_ready = in_sel ? (a_count != 2) : (b_count != 2).
  - Depends only on in_sel and registered occupancy.
  - No combinational path from a_ready or b_ready to in_ready.
  - A full FIFO does not accept a push, even if a pop happens in the same cycle.
- x_valid = (x_count != 0). x_data is the head slot, driven straight from storage. x_data is meaningful only while x_valid is high.
- Occupancy update per edge:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance
- Push and pop on the same FIFO in the same cycle with count 1: the head pops, the new word becomes the head, and count stays 1.
- The two outputs are fully independent. Ordering is preserved within each output and undefined across outputs.
- x_total increments by 1 on each pop and wraps from 0xFFFF_FFFF to 0.
- in_data and in_sel are ignored when in_valid is low.
- No state machine beyond the FIFO pointers and counters. There is no bypass path: an accepted word always spends at least one cycle in the FIFO.

## Timing
- Reset (asynchronous assert, synchronous release on the next clk edge):
  - All pointers, counts, totals and storage clear to 0.
  - Outputs during and after reset: a_valid = b_valid = 0, a_data = b_data = 0, a_count = b_count = 0, a_total = b_total = 0.
  - in_ready = 1.
- Latency: a word accepted at edge N appears as x_valid = 1 with x_data = word immediately after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: one word per cycle into each FIFO while its consumer holds ready high. Alternating in_sel also sustains one word per cycle.
- Reset asserted mid-operation: buffered words are discarded and totals clear. Outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then idle: after deasserting rst, check a_valid = b_valid = 0, counts = 0, totals = 0, in_ready = 1 for both in_sel values.
- Routing: push 0xDEADBEEF with in_sel = 1 and 0x12345678 with in_sel = 0, with a_ready = b_ready = 1 → a_data = 0xDEADBEEF and b_data = 0x12345678, each valid for one cycle, one cycle after acceptance; a_total = b_total = 1.
- Full and backpressure: a_ready = 0; push 1, 2, 3 to a → words 1 and 2 are accepted, a_count = 2, in_ready = 0 on the third. Push 0xAA to b in the same window → accepted. Release a_ready → a delivers 1 then 2, and word 3 is accepted on the cycle after count drops to 1.
- Simultaneous push/pop: with a_count = 1 (head 0x11), push 0x22 while a_ready = 1 → a_count stays 1 and a_data becomes 0x22 after the edge.
- Reset mid-operation: with both FIFOs holding 2 words, pulse rst between edges → valids drop asynchronously; after release, counts and totals are 0 and no stale word is delivered.
- Wrap and stress: preload a_total near 2^32−1 by forcing or long run, pop twice → a_total reads 0xFFFF_FFFF and then 0. Random in_valid, in_sel and ready for 10k cycles against a reference queue → per-output order matches and no loss or duplication.
